// File: rtl/increment.sv
// increment: free-running up-counter with a configurable step and range.
// Past LIMIT it either wraps hard to INIT or saturates at LIMIT.
module increment #(
  parameter int WIDTH     = 5,
  parameter int STEP      = 1,
  parameter int INIT      = 0,
  parameter int LIMIT     = (1 << WIDTH) - 1,
  parameter int WRAP_MODE = 0
) (
  input  logic             clk,
  input  logic             resetn,
  output logic [WIDTH-1:0] t
);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   LIM_X  = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);
  if (STEP < 1 || INIT > LIMIT || LIMIT > (1 << WIDTH) - 1 || STEP > LIMIT - INIT + 1) begin : g_param_err
    $fatal(1, "increment: illegal parameter combination");
  end
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH:0]   sum;
  // The extra sum bit makes "t > LIMIT-STEP" the same test as "t+STEP > LIMIT".
  always_comb begin
    sum = {1'b0, t_q} + STEP_X;
    t_d = (sum > LIM_X) ? ((WRAP_MODE != 0) ? LIM_X[WIDTH-1:0] : INIT_W) : sum[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) t_q <= INIT_W;
    else         t_q <= t_d;
  end
  assign t = t_q;
endmodule

// File: tb/tb_increment.sv
// tb_increment: directed checks of the default wrap counter plus a saturating and a coarse-step wrapping variant.
module tb_increment;
  logic       clk, resetn;
  logic [4:0] t_def, t_sat;
  logic [3:0] t_wrp;
  int errs = 0;
  int checks = 0;

  increment dut_def (.clk(clk), .resetn(resetn), .t(t_def));
  increment #(.WIDTH(5), .STEP(3), .INIT(2), .LIMIT(20), .WRAP_MODE(1))
    dut_sat (.clk(clk), .resetn(resetn), .t(t_sat));
  increment #(.WIDTH(4), .STEP(5), .INIT(1), .LIMIT(15), .WRAP_MODE(0))
    dut_wrp (.clk(clk), .resetn(resetn), .t(t_wrp));

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_def, input int e_sat, input int e_wrp);
    check({tag, "/def"}, 32'(t_def), e_def);
    check({tag, "/sat"}, 32'(t_sat), e_sat);
    check({tag, "/wrp"}, 32'(t_wrp), e_wrp);
  endtask

  initial begin
    int wseq[3] = '{1, 6, 11};
    clk = 1'b1;
    resetn = 1'b0;
    #1 check_all("reset", 0, 2, 1);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 34; k++) begin
      if (k > 0) @(negedge clk);
      #1 check_all($sformatf("moment%0d", k), k % 32, (2 + 3 * k > 20) ? 20 : 2 + 3 * k, wseq[k % 3]);
    end
    repeat (12) @(negedge clk);
    #1 check("reach13", 32'(t_def), 13);
    #4 resetn = 1'b0;
    #1 check_all("midreset_async", 0, 2, 1);
    #2 resetn = 1'b1;
    @(negedge clk);
    #1 check_all("midreset_first_edge", 1, 5, 6);
    resetn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 check_all($sformatf("held%0d", i), 0, 2, 1);
    end
    resetn = 1'b1;
    #1 check_all("release_no_edge", 0, 2, 1);
    @(negedge clk);
    #1 check_all("release_one_edge", 1, 5, 6);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
